// File: rtl/uart_bridge_pkg.sv
// Shared types and encodings for the UART word-to-byte bridge.
// State encoding is one-hot so tx_valid and uart_done decode from a single flop.
package uart_bridge_pkg;

   localparam int LEN_WORD = 32;

   localparam logic [1:0] UART_SIZE_1B = 2'b00;
   localparam logic [1:0] UART_SIZE_2B = 2'b01;
   localparam logic [1:0] UART_SIZE_3B = 2'b10;
   localparam logic [1:0] UART_SIZE_4B = 2'b11;

   typedef enum logic [3:0] {
      UB_STATE_IDLE = 4'b0001,
      UB_STATE_TX   = 4'b0010,
      UB_STATE_RX   = 4'b0100,
      UB_STATE_DONE = 4'b1000
   } ub_state_e;

endpackage

// File: rtl/uart_bridge_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; occupancy is the pointer difference.
// A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module uart_bridge_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    pop_data,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          overrun
);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic        full;
   logic        push_ok;
   logic        pop_ok;

   assign level    = wr_ptr_q - rd_ptr_q;
   assign full     = (level == (AW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign pop_data = mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         overrun  <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push & ~push_ok) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_bridge.sv
// Bridges word-level UART requests from the core to byte-wide TX/RX streams.
// RX bytes are buffered in a FIFO so data arriving before a read is kept.
//
// state | meaning
// IDLE  | waiting for uart_order
// TX    | presenting shreg[7:0] to the transmitter, one byte per handshake
// RX    | popping FIFO bytes into uart_i_data, stalls while FIFO empty
// DONE  | one-cycle uart_done pulse
module uart_bridge
   import uart_bridge_pkg::*;
#(
   parameter int RX_DEPTH = 16,
   parameter int RX_AW    = $clog2(RX_DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                uart_order,
   input  logic                uart_write_flag,
   input  logic [1:0]          uart_size,
   input  logic [LEN_WORD-1:0] uart_o_data,
   output logic [LEN_WORD-1:0] uart_i_data,
   output logic                uart_accepted,
   output logic                uart_done,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic [RX_AW:0]      rx_level,
   output logic                rx_overrun
);

   ub_state_e           state_q;
   ub_state_e           state_d;
   logic [LEN_WORD-1:0] shreg_q;
   logic [LEN_WORD-1:0] i_data_q;
   logic [1:0]          cnt_q;
   logic [1:0]          idx_q;
   logic                accepted_q;
   logic                start;
   logic                tx_hs;
   logic                fifo_pop;
   logic                fifo_empty;
   logic [7:0]          fifo_rdata;

   uart_bridge_byte_fifo #(
      .DEPTH (RX_DEPTH),
      .AW    (RX_AW)
   ) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_valid),
      .push_data (rx_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .empty     (fifo_empty),
      .level     (rx_level),
      .overrun   (rx_overrun)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= UB_STATE_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      tx_hs    = 1'b0;
      fifo_pop = 1'b0;
      unique case (state_q)
         UB_STATE_IDLE: begin
            if (uart_order) begin
               start   = 1'b1;
               state_d = uart_write_flag ? UB_STATE_TX : UB_STATE_RX;
            end
         end
         UB_STATE_TX: begin
            if (tx_ready) begin
               tx_hs = 1'b1;
               if (cnt_q == 2'd0) begin
                  state_d = UB_STATE_DONE;
               end
            end
         end
         UB_STATE_RX: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (idx_q == cnt_q) begin
                  state_d = UB_STATE_DONE;
               end
            end
         end
         UB_STATE_DONE: begin
            state_d = UB_STATE_IDLE;
         end
         default: begin
            state_d = UB_STATE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q    <= '0;
         i_data_q   <= '0;
         cnt_q      <= 2'd0;
         idx_q      <= 2'd0;
         accepted_q <= 1'b0;
      end else begin
         accepted_q <= start;
         if (start) begin
            shreg_q <= uart_o_data;
            cnt_q   <= uart_size;
            idx_q   <= 2'd0;
            // Clearing here zero-extends a short read; TX leaves the last RX word alone.
            if (!uart_write_flag) begin
               i_data_q <= '0;
            end
         end
         if (tx_hs) begin
            shreg_q <= shreg_q >> 8;
            if (cnt_q != 2'd0) begin
               cnt_q <= cnt_q - 2'd1;
            end
         end
         if (fifo_pop) begin
            i_data_q[{idx_q, 3'b000} +: 8] <= fifo_rdata;
            idx_q <= idx_q + 2'd1;
         end
      end
   end

   assign tx_valid      = (state_q == UB_STATE_TX);
   assign tx_data       = shreg_q[7:0];
   assign uart_done     = (state_q == UB_STATE_DONE);
   assign uart_accepted = accepted_q;
   assign uart_i_data   = i_data_q;

endmodule

// File: tb/tb_uart_bridge.sv
// Scoreboard bench for uart_bridge: TX bytes and completed RX words are queued
// when a request is issued and compared when the DUT hands them over.
module tb_uart_bridge;

   localparam int RX_DEPTH = 16;
   localparam int RX_AW    = $clog2(RX_DEPTH);

   logic              clk = 1'b0;
   logic              rst;
   logic              uart_order;
   logic              uart_write_flag;
   logic [1:0]        uart_size;
   logic [31:0]       uart_o_data;
   logic [31:0]       uart_i_data;
   logic              uart_accepted;
   logic              uart_done;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [RX_AW:0]    rx_level;
   logic              rx_overrun;

   typedef struct {
      bit          is_rx;
      logic [31:0] word;
   } done_rec_t;

   logic [7:0] tx_q[$];
   done_rec_t  done_q[$];
   int         total = 0;
   int         bad   = 0;

   uart_bridge #(.RX_DEPTH(RX_DEPTH), .RX_AW(RX_AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .uart_order      (uart_order),
      .uart_write_flag (uart_write_flag),
      .uart_size       (uart_size),
      .uart_o_data     (uart_o_data),
      .uart_i_data     (uart_i_data),
      .uart_accepted   (uart_accepted),
      .uart_done       (uart_done),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .rx_level        (rx_level),
      .rx_overrun      (rx_overrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // returns number of cycles (including the current one) until uart_done is seen
   task automatic wait_done(input int start_cnt, output int cycles);
      cycles = start_cnt;
      while (!uart_done && cycles < 50) begin
         tick();
         cycles++;
      end
      if (!uart_done) check_eq("done_timeout", {31'd0, uart_done}, 32'd1);
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic order(input bit wr, input logic [1:0] size, input logic [31:0] data);
      done_rec_t r;
      uart_order      = 1'b1;
      uart_write_flag = wr;
      uart_size       = size;
      uart_o_data     = data;
      if (wr) begin
         for (int i = 0; i <= int'(size); i++) tx_q.push_back(data[8*i +: 8]);
      end
      r.is_rx = !wr;
      r.word  = 32'd0;
      for (int i = 0; i <= int'(size); i++) r.word[8*i +: 8] = data[8*i +: 8];
      done_q.push_back(r);
      tick();
      uart_order = 1'b0;
      check_eq("accepted", {31'd0, uart_accepted}, 32'd1);
   endtask

   always @(negedge clk) begin
      if (tx_valid && tx_ready) begin
         if (tx_q.size() == 0) check_eq("tx_unexpected", tx_q.size(), 32'd1);
         else check_eq("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
      end
      if (uart_done) begin
         check_eq("acc_done_excl", {31'd0, uart_accepted}, 32'd0);
         if (done_q.size() == 0) check_eq("done_unexpected", done_q.size(), 32'd1);
         else begin
            done_rec_t r;
            r = done_q.pop_front();
            if (r.is_rx) check_eq("rx_word", uart_i_data, r.word);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      rst = 1'b1;
      uart_order = 1'b0; uart_write_flag = 1'b0; uart_size = 2'd0; uart_o_data = 32'd0;
      tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
      tick(); tick();
      check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check_eq("rst_accepted", {31'd0, uart_accepted}, 32'd0);
      check_eq("rst_done", {31'd0, uart_done}, 32'd0);
      check_eq("rst_i_data", uart_i_data, 32'd0);
      check_eq("rst_level", 32'(rx_level), 32'd0);
      check_eq("rst_overrun", {31'd0, rx_overrun}, 32'd0);
      rst = 1'b0;
      tick();

      // TX 4 bytes, ready held high
      tx_ready = 1'b1;
      order(1'b1, 2'b11, 32'h4433_2211);
      check_eq("tx4_first", {24'd0, tx_data}, 32'h11);
      wait_done(1, c);
      check_eq("tx4_latency", c, 32'd5);
      tick();

      // TX 2 bytes with backpressure on the first byte
      tx_ready = 1'b0;
      order(1'b1, 2'b01, 32'h0000_BEEF);
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_hold_data", {24'd0, tx_data}, 32'hEF);
         check_eq("bp_hold_valid", {31'd0, tx_valid}, 32'd1);
         if (i < 2) tick();
      end
      tick();
      tx_ready = 1'b1;
      wait_done(0, c);
      check_eq("bp_latency", c, 32'd2);
      tick();

      // RX with pre-buffered bytes
      rx_push(8'hA1); rx_push(8'hB2); rx_push(8'hC3);
      check_eq("rx_pre_level", 32'(rx_level), 32'd3);
      order(1'b0, 2'b10, 32'h00C3_B2A1);
      wait_done(1, c);
      check_eq("rx_pre_latency", c, 32'd4);
      check_eq("rx_pre_level_end", 32'(rx_level), 32'd0);
      tick();

      // RX starved: byte arrives 10 cycles after the order
      order(1'b0, 2'b00, 32'h0000_005A);
      for (int i = 0; i < 9; i++) begin
         check_eq("starve_no_done", {31'd0, uart_done}, 32'd0);
         tick();
      end
      rx_push(8'h5A);
      wait_done(1, c);
      check_eq("starve_latency", c, 32'd2);
      tick();

      // Overflow: RX_DEPTH+1 pushes with no read
      rx_valid = 1'b1;
      for (int i = 0; i <= RX_DEPTH; i++) begin
         rx_data = 8'h10 + 8'(i);
         tick();
         if (i == RX_DEPTH - 1) begin
            check_eq("ovf_full_level", 32'(rx_level), 32'd16);
            check_eq("ovf_not_yet", {31'd0, rx_overrun}, 32'd0);
         end
      end
      rx_valid = 1'b0;
      check_eq("ovf_level", 32'(rx_level), 32'd16);
      check_eq("ovf_sticky", {31'd0, rx_overrun}, 32'd1);
      // 1-byte read returns the first byte; push while popping a full FIFO is kept
      order(1'b0, 2'b00, 32'h0000_0010);
      rx_data  = 8'h21;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      check_eq("ovf_read_done", {31'd0, uart_done}, 32'd1);
      check_eq("push_pop_level", 32'(rx_level), 32'd16);
      tick();
      order(1'b0, 2'b11, 32'h1413_1211);
      wait_done(1, c);
      check_eq("wrap_latency", c, 32'd5);
      check_eq("wrap_level", 32'(rx_level), 32'd12);
      tick();

      // Reset during the second byte of a 4-byte TX
      order(1'b1, 2'b11, 32'hDDCC_BBAA);
      tick();
      check_eq("rst_mid_byte2", {24'd0, tx_data}, 32'hBB);
      check_eq("tx_keeps_i_data", uart_i_data, 32'h1413_1211);
      void'(tx_q.pop_front()); void'(tx_q.pop_front()); void'(tx_q.pop_front());
      void'(done_q.pop_back());
      #2 rst = 1'b1;
      #1;
      check_eq("rst_async_tx_valid", {31'd0, tx_valid}, 32'd0);
      check_eq("rst_async_level", 32'(rx_level), 32'd0);
      check_eq("rst_async_overrun", {31'd0, rx_overrun}, 32'd0);
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_eq("post_rst_no_done", {31'd0, uart_done}, 32'd0);
      end
      order(1'b1, 2'b00, 32'h0000_005C);
      wait_done(1, c);
      check_eq("post_rst_tx_latency", c, 32'd2);
      tick(); tick();

      check_eq("tx_q_drained", tx_q.size(), 32'd0);
      check_eq("done_q_drained", done_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
